rx_frame_parse_uart1: RTL

//  Receive-side decoder for the UART1 pulse-measurement frame. Consumes the byte stream from the

---
 rtl/rx_frame_parse_uart1.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/rx_frame_parse_uart1.sv
// UART1 pulse-measurement frame decoder: hunts the header, checks the info word and
// unpacks fixed-size index/width/period records with per-frame error reporting.
module rx_frame_parse_uart1 #(
    parameter logic [31:0] HEAD      = 32'h7FFF7FFF,
    parameter int          NUM_PULSE = 12,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rec_valid,
    output logic [4:0]  rec_index,
    output logic [23:0] rec_width,
    output logic [31:0] rec_period,
    output logic [15:0] version,
    output logic [15:0] num_pulse,
    output logic        frame_done,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [15:0] NUM_W    = 16'(NUM_PULSE);
    localparam logic [7:0]  LAST_REC = 8'(NUM_PULSE - 1);

    localparam logic [1:0] ERR_COUNT   = 2'd1;
    localparam logic [1:0] ERR_INDEX   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        INFO = 2'd1,
        REC  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    // Only the three most recent bytes are needed; the fourth is the incoming rx_data.
    logic [23:0] win_q, win_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  rec_cnt_q, rec_cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic [47:0] sh_q, sh_d;

    logic        rec_valid_q, rec_valid_d;
    logic [4:0]  rec_index_q, rec_index_d;
    logic [23:0] rec_width_q, rec_width_d;
    logic [31:0] rec_period_q, rec_period_d;
    logic [15:0] version_q, version_d;
    logic [15:0] num_pulse_q, num_pulse_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic        abort;
    logic [1:0]  abort_code;
    logic [31:0] info_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= HUNT;
            win_q        <= '0;
            byte_cnt_q   <= '0;
            rec_cnt_q    <= '0;
            tmo_q        <= '0;
            sh_q         <= '0;
            rec_valid_q  <= 1'b0;
            rec_index_q  <= '0;
            rec_width_q  <= '0;
            rec_period_q <= '0;
            version_q    <= '0;
            num_pulse_q  <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= '0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            byte_cnt_q   <= byte_cnt_d;
            rec_cnt_q    <= rec_cnt_d;
            tmo_q        <= tmo_d;
            sh_q         <= sh_d;
            rec_valid_q  <= rec_valid_d;
            rec_index_q  <= rec_index_d;
            rec_width_q  <= rec_width_d;
            rec_period_q <= rec_period_d;
            version_q    <= version_d;
            num_pulse_q  <= num_pulse_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        byte_cnt_d   = byte_cnt_q;
        rec_cnt_d    = rec_cnt_q;
        tmo_d        = tmo_q;
        sh_d         = sh_q;
        rec_valid_d  = 1'b0;
        rec_index_d  = rec_index_q;
        rec_width_d  = rec_width_q;
        rec_period_d = rec_period_q;
        version_d    = version_q;
        num_pulse_d  = num_pulse_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = err_cnt_q;
        abort        = 1'b0;
        abort_code   = 2'd0;
        // Info bytes 0..2 sit in the top of the shifter when byte 3 arrives.
        info_word    = {rx_data, sh_q[47:24]};

        if (!ena) begin
            state_d    = HUNT;
            win_d      = '0;
            byte_cnt_d = '0;
            rec_cnt_d  = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (rx_valid) begin
                        if ({rx_data, win_q} == HEAD) begin
                            state_d    = INFO;
                            win_d      = '0;
                            byte_cnt_d = '0;
                            tmo_d      = TIMEOUT;
                        end else begin
                            win_d = {rx_data, win_q[23:8]};
                        end
                    end
                end
                INFO: begin
                    if (rx_valid) begin
                        tmo_d      = TIMEOUT;
                        sh_d       = {rx_data, sh_q[47:8]};
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        if (byte_cnt_q == 3'd3) begin
                            version_d   = info_word[15:0];
                            num_pulse_d = info_word[31:16];
                            byte_cnt_d  = '0;
                            rec_cnt_d   = '0;
                            if (info_word[31:16] != NUM_W) begin
                                abort      = 1'b1;
                                abort_code = ERR_COUNT;
                            end else begin
                                state_d = REC;
                            end
                        end
                    end else if (tmo_q == 16'd0) begin
                        abort      = 1'b1;
                        abort_code = ERR_TIMEOUT;
                    end else begin
                        tmo_d = tmo_q - 16'd1;
                    end
                end
                REC: begin
                    if (rx_valid) begin
                        tmo_d      = TIMEOUT;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        // Byte 0 is only checked; bytes 1..6 shift in, byte 7 completes the record.
                        if (byte_cnt_q == 3'd0) begin
                            if (rx_data != rec_cnt_q) begin
                                abort      = 1'b1;
                                abort_code = ERR_INDEX;
                            end
                        end else if (byte_cnt_q == 3'd7) begin
                            rec_valid_d  = 1'b1;
                            rec_index_d  = rec_cnt_q[4:0];
                            rec_width_d  = sh_q[23:0];
                            rec_period_d = {rx_data, sh_q[47:24]};
                            if (rec_cnt_q == LAST_REC) begin
                                frame_done_d = 1'b1;
                                if (frame_cnt_q != 16'hFFFF) begin
                                    frame_cnt_d = frame_cnt_q + 16'd1;
                                end
                                state_d    = HUNT;
                                win_d      = '0;
                                byte_cnt_d = '0;
                                rec_cnt_d  = '0;
                            end else begin
                                rec_cnt_d = rec_cnt_q + 8'd1;
                            end
                        end else begin
                            sh_d = {rx_data, sh_q[47:8]};
                        end
                    end else if (tmo_q == 16'd0) begin
                        abort      = 1'b1;
                        abort_code = ERR_TIMEOUT;
                    end else begin
                        tmo_d = tmo_q - 16'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    win_d   = '0;
                end
            endcase
        end

        if (abort) begin
            frame_err_d = 1'b1;
            err_code_d  = abort_code;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
            state_d    = HUNT;
            win_d      = '0;
            byte_cnt_d = '0;
            rec_cnt_d  = '0;
        end
    end

    assign rec_valid  = rec_valid_q;
    assign rec_index  = rec_index_q;
    assign rec_width  = rec_width_q;
    assign rec_period = rec_period_q;
    assign version    = version_q;
    assign num_pulse  = num_pulse_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule
